load_bin: RTL and testbench

LOAD_BIN -- requirements
Module: load_bin

---
 rtl/load_bin.sv | 129 ++++++++++++
 tb/tb_load_bin.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/load_bin.sv
// load_bin: streams one bin's clauses, var states and lvl states out of four read-only RAMs
module load_bin #(
    parameter int NUM_CLAUSES_A_BIN = 8,
    parameter int NUM_VARS_A_BIN    = 8,
    parameter int NUM_LVLS_A_BIN    = 8,
    parameter int WIDTH_CLAUSES     = 16,
    parameter int WIDTH_VAR         = 12,
    parameter int WIDTH_LVL         = 16,
    parameter int WIDTH_BIN_ID      = 10,
    parameter int WIDTH_VAR_STATES  = 30,
    parameter int WIDTH_LVL_STATES  = 30,
    parameter int ADDR_WIDTH        = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_load,
    input  logic [WIDTH_BIN_ID-1:0]     cur_bin_num_i,
    input  logic [WIDTH_LVL-1:0]        base_lvl_i,
    output logic                        apply_load_o,
    output logic                        done_load,
    output logic [NUM_CLAUSES_A_BIN-1:0] wr_carray_o,
    output logic [WIDTH_CLAUSES-1:0]    clause_o,
    output logic [NUM_VARS_A_BIN-1:0]   wr_var_states_o,
    output logic [WIDTH_VAR_STATES-1:0] var_state_o,
    output logic [NUM_LVLS_A_BIN-1:0]   wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES-1:0] lvl_state_o,
    output logic [ADDR_WIDTH-1:0]       ram_addr_c_o,
    input  logic [WIDTH_CLAUSES-1:0]    ram_data_c_i,
    output logic [ADDR_WIDTH-1:0]       ram_addr_v_o,
    input  logic [WIDTH_VAR-1:0]        ram_data_v_i,
    output logic [ADDR_WIDTH-1:0]       ram_addr_vs_o,
    input  logic [WIDTH_VAR_STATES-1:0] ram_data_vs_i,
    output logic [ADDR_WIDTH-1:0]       ram_addr_ls_o,
    input  logic [WIDTH_LVL_STATES-1:0] ram_data_ls_i
);
    localparam int K_W = $clog2(NUM_CLAUSES_A_BIN);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [K_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH_BIN_ID-1:0] bin_q;
    logic [WIDTH_LVL-1:0] base_q;
    logic                 load_cyc;
    logic                 v1, v2, v3, e2, e3;
    logic [K_W-1:0]       i1, i2, i3;

    assign load_cyc      = state_q == LOAD;
    assign apply_load_o  = state_q == LOAD || state_q == DRAIN;
    assign done_load     = state_q == DONE;
    assign ram_addr_c_o  = load_cyc ? ADDR_WIDTH'(int'(bin_q) * NUM_CLAUSES_A_BIN + int'(cnt_q)) : '0;
    assign ram_addr_v_o  = load_cyc ? ADDR_WIDTH'(int'(bin_q) * NUM_VARS_A_BIN + int'(cnt_q)) : '0;
    assign ram_addr_ls_o = load_cyc ? ADDR_WIDTH'(int'(base_q) + int'(cnt_q)) : '0;

    // next state: LOAD walks the slot index, DRAIN waits for the var-state pipeline to empty
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start_load) begin
                state_d = LOAD;
                cnt_d   = '0;
            end
            LOAD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == K_W'(NUM_CLAUSES_A_BIN - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == K_W'(3)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state register and request capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && start_load) begin
                bin_q  <= cur_bin_num_i;
                base_q <= base_lvl_i;
            end
        end
    end

    // slot pipeline: RAM latency, then clause/lvl write, then var-state lookup and write
    always_ff @(posedge clk) begin
        if (rst) begin
            {v1, v2, v3, e2, e3} <= '0;
            {i1, i2, i3}         <= '0;
            wr_carray_o          <= '0;
            clause_o             <= '0;
            wr_lvl_states_o      <= '0;
            lvl_state_o          <= '0;
            ram_addr_vs_o        <= '0;
            wr_var_states_o      <= '0;
            var_state_o          <= '0;
        end else begin
            v1              <= load_cyc;
            i1              <= cnt_q;
            v2              <= v1;
            i2              <= i1;
            e2              <= v1 && ram_data_v_i == '0;
            v3              <= v2;
            i3              <= i2;
            e3              <= e2;
            wr_carray_o     <= v1 ? NUM_CLAUSES_A_BIN'(1) << i1 : '0;
            clause_o        <= v1 ? ram_data_c_i : '0;
            wr_lvl_states_o <= v1 ? NUM_LVLS_A_BIN'(1) << i1 : '0;
            lvl_state_o     <= v1 ? ram_data_ls_i : '0;
            ram_addr_vs_o   <= v1 ? ram_data_v_i[ADDR_WIDTH-1:0] : '0;
            wr_var_states_o <= v3 ? NUM_VARS_A_BIN'(1) << i3 : '0;
            var_state_o     <= v3 && !e3 ? ram_data_vs_i : '0;
        end
    end
endmodule

// File: tb/tb_load_bin.sv
// tb_load_bin: scoreboard bench for load_bin with RAM models and a slot-level reference model
module tb_load_bin;
    logic        clk = 0;
    logic        rst = 1;
    logic        start_load = 0;
    logic [9:0]  cur_bin_num_i = 0;
    logic [15:0] base_lvl_i = 0;
    logic        apply_load_o, done_load;
    logic [7:0]  wr_carray_o, wr_var_states_o, wr_lvl_states_o;
    logic [15:0] clause_o;
    logic [29:0] var_state_o, lvl_state_o;
    logic [8:0]  ram_addr_c_o, ram_addr_v_o, ram_addr_vs_o, ram_addr_ls_o;
    logic [15:0] ram_data_c_i;
    logic [11:0] ram_data_v_i;
    logic [29:0] ram_data_vs_i, ram_data_ls_i;

    logic [15:0] memc  [512];
    logic [11:0] memv  [512];
    logic [29:0] memvs [512];
    logic [29:0] memls [512];

    typedef struct {int cyc; logic [127:0] v;} ev_t;
    ev_t cq[$], wq[$], vq[$];

    int cyc = 0, next_ok = 0, vecs = 0, errs = 0;
    bit mon_en = 0;

    load_bin dut (
        .clk(clk), .rst(rst), .start_load(start_load), .cur_bin_num_i(cur_bin_num_i),
        .base_lvl_i(base_lvl_i), .apply_load_o(apply_load_o), .done_load(done_load),
        .wr_carray_o(wr_carray_o), .clause_o(clause_o), .wr_var_states_o(wr_var_states_o),
        .var_state_o(var_state_o), .wr_lvl_states_o(wr_lvl_states_o), .lvl_state_o(lvl_state_o),
        .ram_addr_c_o(ram_addr_c_o), .ram_data_c_i(ram_data_c_i), .ram_addr_v_o(ram_addr_v_o),
        .ram_data_v_i(ram_data_v_i), .ram_addr_vs_o(ram_addr_vs_o), .ram_data_vs_i(ram_data_vs_i),
        .ram_addr_ls_o(ram_addr_ls_o), .ram_data_ls_i(ram_data_ls_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        ram_data_c_i  <= memc[ram_addr_c_o];
        ram_data_v_i  <= memv[ram_addr_v_o];
        ram_data_vs_i <= memvs[ram_addr_vs_o];
        ram_data_ls_i <= memls[ram_addr_ls_o];
    end

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
        end
    endtask

    // reference: what one accepted load at cycle t must produce, slot by slot
    task automatic model(input int t, input int b, input int l);
        logic [8:0] ac, av, al, avs;
        logic [7:0] oh;
        logic [29:0] vs;
        for (int k = 0; k < 13; k++) begin
            ac = k < 8 ? 9'((b * 8 + k) % 512) : 9'd0;
            al = k < 8 ? 9'((l + k) % 512) : 9'd0;
            cq.push_back('{t + 1 + k, 128'({k < 12, k == 12, ac, ac, al})});
        end
        for (int k = 0; k < 8; k++) begin
            av  = 9'((b * 8 + k) % 512);
            al  = 9'((l + k) % 512);
            avs = 9'(memv[av] % 512);
            oh  = 8'(1 << k);
            vs  = memv[av] == 0 ? 30'd0 : memvs[avs];
            wq.push_back('{t + 3 + k, 128'({oh, memc[av], oh, memls[al], avs})});
            vq.push_back('{t + 5 + k, 128'({oh, vs})});
        end
    endtask

    task automatic step(input bit s, input int b, input int l, input bit r);
        @(posedge clk);
        #1;
        start_load = s;
        cur_bin_num_i = 10'(b);
        base_lvl_i = 16'(l);
        rst = r;
        if (r) begin
            while (cq.size() && cq[$].cyc > cyc) void'(cq.pop_back());
            while (wq.size() && wq[$].cyc > cyc) void'(wq.pop_back());
            while (vq.size() && vq[$].cyc > cyc) void'(vq.pop_back());
            next_ok = cyc + 1;
        end else if (s && cyc >= next_ok) begin
            model(cyc, b, l);
            next_ok = cyc + 14;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic fill(input bit ident);
        for (int a = 0; a < 512; a++) begin
            memc[a]  = ident ? 16'(a) : 16'($urandom);
            memls[a] = ident ? 30'(a) : 30'($urandom);
            memvs[a] = 30'($urandom);
            memv[a]  = $urandom_range(0, 3) == 0 ? 12'd0 : 12'($urandom);
        end
    endtask

    // monitor: pops the expected event whose cycle has come, else demands quiet outputs
    always @(negedge clk) begin
        logic [127:0] e;
        if (mon_en) begin
            e = '0;
            if (cq.size() && cq[0].cyc == cyc) e = cq.pop_front().v;
            chk("ctl", 128'({apply_load_o, done_load, ram_addr_c_o, ram_addr_v_o, ram_addr_ls_o}), e);
            e = '0;
            if (wq.size() && wq[0].cyc == cyc) e = wq.pop_front().v;
            chk("clause_lvl", 128'({wr_carray_o, clause_o, wr_lvl_states_o, lvl_state_o, ram_addr_vs_o}), e);
            e = '0;
            if (vq.size() && vq[0].cyc == cyc) e = vq.pop_front().v;
            chk("var_state", 128'({wr_var_states_o, var_state_o}), e);
        end
    end

    initial begin
        fill(1);
        memv[24] = 7;
        memv[25] = 0;
        memv[26] = 9;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        mon_en = 1;
        step(0, 0, 0, 1);
        idle(2);
        step(1, 3, 5, 0);
        idle(3);
        step(1, 11, 100, 0);
        idle(9);
        step(1, 63, 510, 0);
        idle(13);
        step(1, 5, 65530, 0);
        idle(5);
        step(0, 0, 0, 1);
        idle(3);
        step(1, 3, 5, 0);
        idle(20);
        fill(0);
        for (int i = 0; i < 700; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 1023), $urandom_range(0, 65535),
                 $urandom_range(0, 149) == 0);
        idle(20);
        chk("ctl_left", 128'(cq.size()), 128'(0));
        chk("clause_left", 128'(wq.size()), 128'(0));
        chk("var_left", 128'(vq.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
